stream_demultiplexer: RTL and testbench

//   Valid/ready stream demultiplexer: routes one input word to one of NUMBER_OF_OUTPUTS

---
 rtl/stream_demultiplexer.sv | 84 ++++++++
 tb/tb_stream_demultiplexer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_demultiplexer.sv
// Valid/ready stream demultiplexer: routes each accepted word to one output channel or to all
// of them, with a single-entry holding slot per channel so one stalled consumer blocks only its own traffic.
module stream_demultiplexer #(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    NUMBER_OF_OUTPUTS = 4,
    parameter int                    SELECT_WIDTH      = $clog2(NUMBER_OF_OUTPUTS),
    parameter logic [DATA_WIDTH-1:0] INACTIVE_VALUE    = '0,
    parameter int                    COUNTER_WIDTH     = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        inputData,
    input  logic [SELECT_WIDTH-1:0]      inputSelect,
    input  logic                         inputBroadcast,
    input  logic                         inputValid,
    output logic                         inputReady,
    output logic [DATA_WIDTH-1:0]        outputData [NUMBER_OF_OUTPUTS],
    output logic [NUMBER_OF_OUTPUTS-1:0] outputValid,
    input  logic [NUMBER_OF_OUTPUTS-1:0] outputReady,
    output logic                         dropPulse,
    output logic [COUNTER_WIDTH-1:0]     droppedCount
);

    localparam logic [SELECT_WIDTH:0] NumOutputs = (SELECT_WIDTH + 1)'(NUMBER_OF_OUTPUTS);

    logic [DATA_WIDTH-1:0]        slotData [NUMBER_OF_OUTPUTS];
    logic [NUMBER_OF_OUTPUTS-1:0] slotValid;
    logic [NUMBER_OF_OUTPUTS-1:0] slotFree;
    logic [NUMBER_OF_OUTPUTS-1:0] targetMask;
    logic                         selectInRange;
    logic                         accept;
    logic                         dropNext;

    always_comb begin
        slotFree      = ~slotValid | outputReady;
        selectInRange = {1'b0, inputSelect} < NumOutputs;
        targetMask    = '0;
        for (int unsigned i = 0; i < NUMBER_OF_OUTPUTS; i++) begin
            targetMask[i] = inputBroadcast || (inputSelect == SELECT_WIDTH'(i));
        end
        // Broadcast waits for every slot so all channels load together or none do.
        if (inputBroadcast) begin
            inputReady = &slotFree;
        end else if (selectInRange) begin
            inputReady = |(targetMask & slotFree);
        end else begin
            inputReady = 1'b1;
        end
        accept   = inputValid && inputReady;
        dropNext = accept && !inputBroadcast && !selectInRange;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            slotValid    <= '0;
            dropPulse    <= 1'b0;
            droppedCount <= '0;
            for (int unsigned i = 0; i < NUMBER_OF_OUTPUTS; i++) begin
                slotData[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUMBER_OF_OUTPUTS; i++) begin
                if (accept && targetMask[i]) begin
                    slotValid[i] <= 1'b1;
                    slotData[i]  <= inputData;
                end else if (slotValid[i] && outputReady[i]) begin
                    slotValid[i] <= 1'b0;
                end
            end
            dropPulse <= dropNext;
            if (dropNext && (droppedCount != '1)) begin
                droppedCount <= droppedCount + COUNTER_WIDTH'(1);
            end
        end
    end

    always_comb begin
        outputValid = slotValid;
        for (int unsigned i = 0; i < NUMBER_OF_OUTPUTS; i++) begin
            outputData[i] = slotValid[i] ? slotData[i] : INACTIVE_VALUE;
        end
    end

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Directed bench for stream_demultiplexer: a 4-channel instance for routing/backpressure/broadcast
// and a 3-channel, 2-bit-counter instance for out-of-range drops and saturation.
module tb_stream_demultiplexer;

    localparam logic [31:0] InactiveA = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset;

    logic [31:0] inDataA;
    logic [1:0]  selA;
    logic        bcastA;
    logic        validInA;
    logic        readyInA;
    logic [31:0] dataA [4];
    logic [3:0]  validA;
    logic [3:0]  readyA;
    logic        dropA;
    logic [15:0] droppedA;

    logic [7:0]  inDataB;
    logic [1:0]  selB;
    logic        bcastB;
    logic        validInB;
    logic        readyInB;
    logic [7:0]  dataB [3];
    logic [2:0]  validB;
    logic [2:0]  readyB;
    logic        dropB;
    logic [1:0]  droppedB;

    int unsigned checkCount = 0;
    int unsigned passCount  = 0;

    always #5 clock = ~clock;

    stream_demultiplexer #(
        .DATA_WIDTH       (32),
        .NUMBER_OF_OUTPUTS(4),
        .INACTIVE_VALUE   (InactiveA),
        .COUNTER_WIDTH    (16)
    ) dutA (
        .clock         (clock),
        .reset         (reset),
        .inputData     (inDataA),
        .inputSelect   (selA),
        .inputBroadcast(bcastA),
        .inputValid    (validInA),
        .inputReady    (readyInA),
        .outputData    (dataA),
        .outputValid   (validA),
        .outputReady   (readyA),
        .dropPulse     (dropA),
        .droppedCount  (droppedA)
    );

    stream_demultiplexer #(
        .DATA_WIDTH       (8),
        .NUMBER_OF_OUTPUTS(3),
        .COUNTER_WIDTH    (2)
    ) dutB (
        .clock         (clock),
        .reset         (reset),
        .inputData     (inDataB),
        .inputSelect   (selB),
        .inputBroadcast(bcastB),
        .inputValid    (validInB),
        .inputReady    (readyInB),
        .outputData    (dataB),
        .outputValid   (validB),
        .outputReady   (readyB),
        .dropPulse     (dropB),
        .droppedCount  (droppedB)
    );

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] expCount [5];
        expCount = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        reset    = 1'b0;
        inDataA  = '0; selA = '0; bcastA = 1'b0; validInA = 1'b0; readyA = 4'b1111;
        inDataB  = '0; selB = '0; bcastB = 1'b0; validInB = 1'b0; readyB = 3'b111;
        tick();
        tick();
        checkValue("rst_validA", 32'(validA), 32'h0);
        checkValue("rst_dataA0", dataA[0], InactiveA);
        checkValue("rst_dataA3", dataA[3], InactiveA);
        checkValue("rst_countA", 32'(droppedA), 32'h0);
        checkValue("rst_dropA", 32'(dropA), 32'h0);
        checkValue("rst_validB", 32'(validB), 32'h0);
        reset = 1'b1;

        // 1. reset mid-stream with slot 2 held
        readyA = 4'b1011; selA = 2'd2; inDataA = 32'h22; validInA = 1'b1;
        #1 checkValue("t1_ready", 32'(readyInA), 32'h1);
        tick();
        validInA = 1'b0;
        checkValue("t1_validHeld", 32'(validA), 32'h4);
        checkValue("t1_dataHeld", dataA[2], 32'h22);
        checkValue("t1_dataIdle0", dataA[0], InactiveA);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkValue("t1_validRst", 32'(validA), 32'h0);
        checkValue("t1_dataRst2", dataA[2], InactiveA);
        checkValue("t1_countRst", 32'(droppedA), 32'h0);
        readyA = 4'b1111;

        // 2. unicast streaming on channel 1
        for (int k = 0; k < 16; k++) begin
            selA = 2'd1; inDataA = 32'h10 + 32'(k); validInA = 1'b1;
            #1 checkValue("t2_ready", 32'(readyInA), 32'h1);
            tick();
            checkValue("t2_valid", 32'(validA), 32'h2);
            checkValue("t2_data", dataA[1], 32'h10 + 32'(k));
        end
        validInA = 1'b0;
        tick();
        checkValue("t2_drained", 32'(validA), 32'h0);

        // 3. backpressure isolation
        readyA = 4'b1110; selA = 2'd0; inDataA = 32'hA; validInA = 1'b1;
        #1 checkValue("t3_readyA", 32'(readyInA), 32'h1);
        tick();
        inDataA = 32'hB;
        #1 checkValue("t3_stallB", 32'(readyInA), 32'h0);
        tick();
        checkValue("t3_heldValid", 32'(validA), 32'h1);
        checkValue("t3_heldA", dataA[0], 32'hA);
        selA = 2'd3; inDataA = 32'hC;
        #1 checkValue("t3_readyC", 32'(readyInA), 32'h1);
        tick();
        checkValue("t3_validC", 32'(validA), 32'h9);
        checkValue("t3_dataC", dataA[3], 32'hC);
        checkValue("t3_stillA", dataA[0], 32'hA);
        selA = 2'd0; inDataA = 32'hB;
        #1 checkValue("t3_stallB2", 32'(readyInA), 32'h0);
        tick();
        checkValue("t3_ch3Drained", 32'(validA), 32'h1);
        readyA = 4'b1111;
        #1 checkValue("t3_readyB", 32'(readyInA), 32'h1);
        tick();
        validInA = 1'b0;
        checkValue("t3_validB", 32'(validA), 32'h1);
        checkValue("t3_dataB", dataA[0], 32'hB);
        tick();
        checkValue("t3_idle", 32'(validA), 32'h0);

        // 4. broadcast with channel 2 stalled
        readyA = 4'b1011; selA = 2'd2; inDataA = 32'h77; validInA = 1'b1;
        tick();
        bcastA = 1'b1; selA = 2'd0; inDataA = 32'h55;
        #1 checkValue("t4_stall", 32'(readyInA), 32'h0);
        tick();
        checkValue("t4_noPartial", 32'(validA), 32'h4);
        checkValue("t4_held2", dataA[2], 32'h77);
        checkValue("t4_idle1", dataA[1], InactiveA);
        readyA = 4'b1111;
        #1 checkValue("t4_ready", 32'(readyInA), 32'h1);
        tick();
        validInA = 1'b0; bcastA = 1'b0;
        checkValue("t4_allValid", 32'(validA), 32'hF);
        for (int i = 0; i < 4; i++) begin
            checkValue("t4_data", dataA[i], 32'h55);
        end
        checkValue("t4_noDrop", 32'(dropA), 32'h0);
        tick();
        checkValue("t4_idle", 32'(validA), 32'h0);

        // 5. out-of-range drops with saturation on the 3-channel instance
        selB = 2'd3; inDataB = 8'h99; validInB = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 checkValue("t5_ready", 32'(readyInB), 32'h1);
            tick();
            checkValue("t5_pulse", 32'(dropB), 32'h1);
            checkValue("t5_count", 32'(droppedB), 32'(expCount[k]));
            checkValue("t5_noValid", 32'(validB), 32'h0);
        end
        selB = 2'd2; inDataB = 8'h09;
        tick();
        validInB = 1'b0;
        checkValue("t5_pulseEnd", 32'(dropB), 32'h0);
        checkValue("t5_countHold", 32'(droppedB), 32'h3);
        checkValue("t5_routeValid", 32'(validB), 32'h4);
        checkValue("t5_routeData", 32'(dataB[2]), 32'h09);
        checkValue("t5_idleData0", 32'(dataB[0]), 32'h0);

        // 6. drain and refill in the same cycle
        readyA = 4'b1101; selA = 2'd1; inDataA = 32'h61; validInA = 1'b1;
        tick();
        checkValue("t6_full", 32'(validA), 32'h2);
        readyA = 4'b1111; inDataA = 32'h62;
        #1 checkValue("t6_ready", 32'(readyInA), 32'h1);
        tick();
        validInA = 1'b0;
        checkValue("t6_valid", 32'(validA), 32'h2);
        checkValue("t6_data", dataA[1], 32'h62);
        tick();
        checkValue("t6_idle", 32'(validA), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
